interrupt_injector: RTL and testbench
=====================================

Name: interrupt_injector

Overview:
- Consumer end of the `interrupt_instruction` bus that the input controller drives toward the CPU.
- Detects each new interrupt word, queues it in a small FIFO, and hands the words one at a time to the CPU fetch stage.
- Holds the PC while a queued word occupies the fetch slot.
- Spaces injections apart so the previous interrupt handler's register writeback finishes before the next word issues.
- Instantiated inside CPU, clocked by the processor clock.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- GAP, 5: cycles after an accepted injection before the next one may issue; covers pipeline depth to writeback; range 0..15.

Ports:
- clock  input  1  processor clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- interrupt_instruction  input  32  word from the input controller; 32'd0 means no request.
- inject_ready  input  1  fetch stage can take an injected word this cycle.
- inject_valid  output  1  word on inject_instruction is offered to fetch.
- inject_instruction  output  32  word to substitute for the imem fetch; 32'd0 when inject_valid=0.
- fetch_hold  output  1  PC must not advance this cycle; equals inject_valid.
- pending_count  output  5  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a request was dropped because the FIFO was full.

Behaviour:
- Reset (reset=1 at a clock edge) sets these values, and any in-flight injection is abandoned:
  - FIFO empty, pending_count=0.
  - State IDLE, gap counter 0.
  - inject_valid=0, inject_instruction=0, overflow=0.
  - prev_word register = 0.
- Request detection:
  - prev_word registers interrupt_instruction every cycle.
  - A new request exists in a cycle when interrupt_instruction != 0 and interrupt_instruction != prev_word.
  - A word held constant for many cycles therefore enqueues once.
  - A change from one nonzero word to a different nonzero word enqueues the new word.
- Enqueue:
  - A new request writes to the tail at the next edge.
  - If the FIFO is full and no dequeue happens in the same cycle, the word is dropped and overflow is set to 1 at the next edge. overflow stays 1 until reset.
  - A simultaneous enqueue and dequeue on a full FIFO succeeds: count stays DEPTH, no overflow.
- State machine, IDLE -> ISSUE -> GAP -> IDLE:
  - IDLE: inject_valid=0. If the FIFO is non-empty, go to ISSUE at the next edge.
  - ISSUE:
    - Combinationally, inject_valid=1 and inject_instruction=FIFO head.
    - On an edge with inject_ready=1: pop the head, load the gap counter with GAP, and go to GAP. If GAP=0, go directly to IDLE.
    - With inject_ready=0: hold; the head word must stay stable.
  - GAP:
    - inject_valid=0.
    - The counter decrements each cycle; on reaching 1, go to IDLE at that edge.
    - Enqueues continue during GAP.
- Latency and throughput:
  - Request seen at edge N: enqueued at N+1, ISSUE from N+2, inject_valid high in cycle N+2.
  - Minimum spacing between two accepted injections is GAP+2 cycles.
- Ordering: strict FIFO order; no coalescing or reordering.
- pending_count updates:
  - enqueue only: +1.
  - dequeue only: -1.
  - both: unchanged.
  - The enqueue/dequeue counts always match the pointer difference.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from a count register, not from pointer equality alone.
- fetch_hold is identical to inject_valid, including during inject_ready=0 stalls.

Test Plan:
- Reset, then hold interrupt_instruction=0 for 20 cycles -> inject_valid=0, pending_count=0, overflow=0 throughout.
- Set interrupt_instruction=32'hA000_0001 for 10 cycles with inject_ready=1 -> exactly one injection:
  - inject_valid high for 1 cycle, 2 cycles after the word appears;
  - pending_count goes 0->1->0.
- Apply words 0x11, 0x22, 0x33 on consecutive cycles, inject_ready=1, GAP=5 -> injections occur in order 0x11, 0x22, 0x33, spaced 7 cycles apart.
- Hold inject_ready=0 while one word is queued -> inject_valid=1, fetch_hold=1, and the word stays stable for 8 cycles. Raise inject_ready -> pop on that edge, then inject_valid=0 for 5 cycles.
- Push 6 distinct words back-to-back with inject_ready=0 (DEPTH=4) -> pending_count=4, overflow=1. Releasing inject_ready delivers only the first 4 words.
- Assert reset while in ISSUE with 3 words queued -> next cycle inject_valid=0, pending_count=0, overflow=0. A subsequent new word injects normally.

Source files
------------

// File: rtl/interrupt_injector.sv
// ---------------------------------------------------------------------------
// interrupt_injector
//
// Consumer end of the interrupt_instruction bus from the input controller.
// Every new nonzero word is queued in a small FIFO. Queued words are offered
// one at a time to the CPU fetch stage in place of the imem word, and the PC
// is held while a word occupies the fetch slot. After each accepted injection
// a gap of GAP cycles lets the previous handler's writeback drain before the
// next word is offered.
//
// Parameters
//   DEPTH  FIFO entries, power of two, 2..16
//   GAP    idle cycles after an accepted injection, 0..15
//
// Ports
//   clock                  processor clock, rising edge
//   reset                  synchronous, active-high
//   interrupt_instruction  request word; 0 means no request
//   inject_ready           fetch stage takes the offered word this cycle
//   inject_valid           inject_instruction holds an offered word
//   inject_instruction     offered word, 0 when inject_valid is low
//   fetch_hold             PC hold, identical to inject_valid
//   pending_count          FIFO occupancy, 0..DEPTH
//   overflow               sticky: a request was dropped on a full FIFO
// ---------------------------------------------------------------------------
module interrupt_injector #(
    parameter int DEPTH = 4,
    parameter int GAP   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] interrupt_instruction,
    input  logic        inject_ready,
    output logic        inject_valid,
    output logic [31:0] inject_instruction,
    output logic        fetch_hold,
    output logic [4:0]  pending_count,
    output logic        overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic [31:0]        prev_word;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [4:0]         count;

    logic new_req;
    logic full;
    logic empty;
    logic deq;
    logic enq;
    logic drop;

    // A word counts as a request only on the cycle it first appears, so a
    // word held on the bus for many cycles is queued once.
    assign new_req = (interrupt_instruction != 32'd0) &&
                     (interrupt_instruction != prev_word);

    assign full  = (count == 5'(DEPTH));
    assign empty = (count == 5'd0);
    assign deq   = (state == ST_ISSUE) && inject_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign enq   = new_req && (!full || deq);
    assign drop  = new_req && full && !deq;

    // ---------------------------------------------------------------------
    // Request edge detector, occupancy and overflow flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_word <= 32'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 5'd0;
            overflow  <= 1'b0;
        end else begin
            prev_word <= interrupt_instruction;
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (enq) mem[wr_ptr] <= interrupt_instruction;
    end

    // ---------------------------------------------------------------------
    // Issue sequencer: IDLE -> ISSUE -> GAP -> IDLE
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (!empty) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (inject_ready) begin
                    if (GAP == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_GAP;
                        gap_cnt_nxt = 4'(GAP);
                    end
                end
            end
            ST_GAP: begin
                // Leaving on the cycle the counter shows 1 gives exactly GAP
                // cycles in this state.
                if (gap_cnt <= 4'd1) begin
                    state_nxt   = ST_IDLE;
                    gap_cnt_nxt = 4'd0;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                gap_cnt_nxt = 4'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign inject_valid       = (state == ST_ISSUE);
    assign fetch_hold         = inject_valid;
    assign inject_instruction = inject_valid ? mem[rd_ptr] : 32'd0;
    assign pending_count      = count;

endmodule

// File: tb/tb_interrupt_injector.sv
// ---------------------------------------------------------------------------
// Testbench for interrupt_injector.
// Reference model: a word queue plus a timing rule ("a word is offered the
// cycle after the queue is seen non-empty, no earlier than GAP+1 cycles after
// the previous acceptance"). Outputs are compared every cycle on the falling
// edge; directed scenarios add scenario-level checks on the accepted stream.
// ---------------------------------------------------------------------------
module tb_interrupt_injector;

    localparam int DEPTH = 4;
    localparam int GAP   = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] interrupt_instruction;
    logic        inject_ready;
    logic        inject_valid;
    logic [31:0] inject_instruction;
    logic        fetch_hold;
    logic [4:0]  pending_count;
    logic        overflow;

    interrupt_injector #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .interrupt_instruction (interrupt_instruction),
        .inject_ready          (inject_ready),
        .inject_valid          (inject_valid),
        .inject_instruction    (inject_instruction),
        .fetch_hold            (fetch_hold),
        .pending_count         (pending_count),
        .overflow              (overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];
    logic [31:0] m_prev;
    bit          m_offer;
    bit          m_ovf;
    int          m_cyc;
    int          m_last_acc;

    // DUT-observed acceptances, for scenario checks
    logic [31:0] acc_words[$];
    int          acc_cyc[$];

    function automatic void model_edge();
        bit deq, new_req;
        int old_size;
        if (reset) begin
            m_q.delete();
            m_prev     = 32'd0;
            m_offer    = 1'b0;
            m_ovf      = 1'b0;
            m_last_acc = -100;
        end else begin
            old_size = m_q.size();
            deq      = m_offer && inject_ready;
            new_req  = (interrupt_instruction != 0) && (interrupt_instruction != m_prev);
            if (m_offer) begin
                if (inject_ready) begin
                    m_offer    = 1'b0;
                    m_last_acc = m_cyc;
                end
            end else if (old_size > 0 && m_cyc >= m_last_acc + GAP + 1) begin
                m_offer = 1'b1;
            end
            if (deq) void'(m_q.pop_front());
            if (new_req) begin
                if (old_size < DEPTH || deq) m_q.push_back(interrupt_instruction);
                else m_ovf = 1'b1;
            end
            m_prev = interrupt_instruction;
        end
        m_cyc++;
    endfunction

    // One cycle: check at negedge, advance model at posedge, return 1 later.
    task automatic tick();
        bit acc;
        @(negedge clock);
        chk("valid", 32'(inject_valid), 32'(m_offer));
        chk("hold",  32'(fetch_hold),   32'(m_offer));
        chk("instr", inject_instruction, m_offer ? m_q[0] : 32'd0);
        chk("count", 32'(pending_count), 32'(m_q.size()));
        chk("ovf",   32'(overflow),      32'(m_ovf));
        acc = inject_valid && inject_ready && !reset;
        if (acc) begin
            acc_words.push_back(inject_instruction);
            acc_cyc.push_back(m_cyc);
        end
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        interrupt_instruction = 32'd0;
        tick();
        reset = 1'b0;
        acc_words.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int t0;
        logic [31:0] w6 [6];
        reset = 1'b1;
        interrupt_instruction = 32'd0;
        inject_ready = 1'b0;
        m_cyc = 0;
        repeat (2) begin
            @(posedge clock);
            model_edge();
        end
        #1;

        // 1: idle bus
        reset = 1'b0;
        repeat (20) tick();
        chk("idle_count", 32'(pending_count), 32'd0);

        // 2: held word injects once, two cycles after appearing
        do_reset();
        inject_ready = 1'b1;
        interrupt_instruction = 32'hA000_0001;
        t0 = m_cyc;
        repeat (10) tick();
        interrupt_instruction = 32'd0;
        repeat (5) tick();
        chk("hold_once_n", 32'(acc_words.size()), 32'd1);
        if (acc_cyc.size() > 0) chk("hold_once_lat", 32'(acc_cyc[0] - t0), 32'd2);

        // 3: three words back to back, spaced GAP+2
        do_reset();
        inject_ready = 1'b1;
        interrupt_instruction = 32'h11; tick();
        interrupt_instruction = 32'h22; tick();
        interrupt_instruction = 32'h33; tick();
        interrupt_instruction = 32'h0;
        repeat (25) tick();
        chk("seq_n", 32'(acc_words.size()), 32'd3);
        if (acc_words.size() == 3) begin
            chk("seq_w0", acc_words[0], 32'h11);
            chk("seq_w1", acc_words[1], 32'h22);
            chk("seq_w2", acc_words[2], 32'h33);
            chk("seq_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(GAP + 2));
            chk("seq_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(GAP + 2));
        end

        // 4: stall with one word queued
        do_reset();
        inject_ready = 1'b0;
        interrupt_instruction = 32'h44; tick();
        interrupt_instruction = 32'h0;  tick();
        repeat (8) begin
            tick();
            chk("stall_valid", 32'(inject_valid), 32'd1);
            chk("stall_word", inject_instruction, 32'h44);
        end
        inject_ready = 1'b1;
        tick();
        repeat (5) begin
            tick();
            chk("post_gap_valid", 32'(inject_valid), 32'd0);
        end

        // 5: overflow with six words against DEPTH=4
        do_reset();
        inject_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w6[i] = 32'h100 + 32'(i);
            interrupt_instruction = w6[i];
            tick();
        end
        interrupt_instruction = 32'h0;
        repeat (2) tick();
        chk("ovf_count", 32'(pending_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        inject_ready = 1'b1;
        repeat (40) tick();
        chk("ovf_n", 32'(acc_words.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < acc_words.size()) chk("ovf_word", acc_words[i], w6[i]);

        // 6: reset in ISSUE with three queued
        do_reset();
        inject_ready = 1'b0;
        interrupt_instruction = 32'h201; tick();
        interrupt_instruction = 32'h202; tick();
        interrupt_instruction = 32'h203; tick();
        interrupt_instruction = 32'h0;   tick();
        chk("pre_rst_valid", 32'(inject_valid), 32'd1);
        do_reset();
        chk("rst_valid", 32'(inject_valid), 32'd0);
        chk("rst_count", 32'(pending_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        inject_ready = 1'b1;
        interrupt_instruction = 32'h300;
        repeat (10) tick();
        chk("post_rst_n", 32'(acc_words.size()), 32'd1);
        if (acc_words.size() > 0) chk("post_rst_w", acc_words[0], 32'h300);

        // 7: randomized traffic, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r >= 6) interrupt_instruction = 32'($urandom_range(1, 6));
            else if (r >= 4) interrupt_instruction = 32'd0;
            inject_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
